// File: rtl/mac_tile_mk.sv
// mac_tile_mk: weight-/output-stationary systolic MAC tile; define MAC_TILE_SAT_EN for saturating sums and a sticky sat_seen flag
module mac_tile_mk #(
  parameter int bw = 4,
  parameter int psum_bw = 16,
  parameter int KDEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  input  logic [2:0]         inst_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [bw-1:0]      out_e,
  output logic [2:0]         inst_e,
  output logic [psum_bw-1:0] out_s
);
  localparam int PW = $clog2(KDEPTH);
  localparam logic [PW-1:0] LAST = PW'(KDEPTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_d;
  logic signed [bw-1:0] wbuf [KDEPTH];
  logic signed [bw-1:0] wbuf_d [KDEPTH];
  logic [PW-1:0] wr_ptr, wr_d, rd_ptr, rd_d;
  logic full, full_d;
  logic signed [psum_bw-1:0] acc, acc_d, out_d, pw_s, po_s;
  logic ld, ex, dr, abort;
  function automatic logic signed [psum_bw-1:0] prod(input logic [bw-1:0] a, input logic signed [bw-1:0] w);
    return psum_bw'($signed({1'b0, a})) * psum_bw'(w);
  endfunction
`ifdef MAC_TILE_SAT_EN
  function automatic logic ovf(input logic signed [psum_bw-1:0] a, input logic signed [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    return s[psum_bw] ^ s[psum_bw-1];
  endfunction
  function automatic logic signed [psum_bw-1:0] sum(input logic signed [psum_bw-1:0] a, input logic signed [psum_bw-1:0] b);
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    return (s[psum_bw] ^ s[psum_bw-1]) ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}} : s[psum_bw-1:0];
  endfunction
`else
  function automatic logic signed [psum_bw-1:0] sum(input logic signed [psum_bw-1:0] a, input logic signed [psum_bw-1:0] b);
    return a + b;
  endfunction
`endif
  assign ld = inst_w[0];
  assign ex = inst_w[1];
  assign dr = inst_w[2];
  assign abort = !mode && state != IDLE;
  assign pw_s = prod(in_w, wbuf[rd_ptr]);
  assign po_s = prod(in_w, in_n[bw-1:0]);
  // OS state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;
  // OS next state: WS mode and aborted OS operations fall back to IDLE
  always_comb
    state_d = !mode ? IDLE : dr ? DRAIN : (ex && state != DRAIN) ? RUN : IDLE;
  // datapath next values: weight buffer in WS, accumulator in OS, south output in both
  always_comb begin
    wbuf_d = wbuf;
    wr_d = wr_ptr;
    rd_d = rd_ptr;
    full_d = full;
    acc_d = acc;
    out_d = '0;
    if (!mode) begin
      if (dr) begin
        full_d = 1'b0;
        wr_d = '0;
        rd_d = '0;
      end else begin
        if (ld && !full) begin
          wbuf_d[wr_ptr] = in_w;
          wr_d = wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
          full_d = wr_ptr == LAST;
        end
        if (ex) begin
          out_d = sum(in_n, pw_s);
          rd_d = rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        end
      end
      if (abort) begin
        acc_d = '0;
        out_d = '0;
      end
    end else if (dr) begin
      out_d = state == DRAIN ? in_n : acc;
      acc_d = '0;
    end else if (ex && state != DRAIN) begin
      acc_d = sum(acc, po_s);
      out_d = in_n;
    end
  end
  // register datapath state and all outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wbuf <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      full <= 1'b0;
      acc <= '0;
      out_s <= '0;
      out_e <= '0;
      inst_e <= '0;
    end else begin
      wbuf <= wbuf_d;
      wr_ptr <= wr_d;
      rd_ptr <= rd_d;
      full <= full_d;
      acc <= acc_d;
      out_s <= out_d;
      out_e <= (ld || ex) ? in_w : out_e;
      inst_e <= {inst_w[2:1], ld & (mode | full)};
    end
`ifdef MAC_TILE_SAT_EN
  logic sat_seen, ws_ex, os_ac;
  assign ws_ex = !mode && ex && !dr && !abort;
  assign os_ac = mode && ex && !dr && state != DRAIN;
  // sticky record of any clamp, cleared only by reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sat_seen <= 1'b0;
    else if ((ws_ex && ovf(in_n, pw_s)) || (os_ac && ovf(acc, po_s))) sat_seen <= 1'b1;
`endif
endmodule

// File: tb/tb_mac_tile_mk.sv
// tb_mac_tile_mk: directed table, reset/saturation sequences and randomized model check of mac_tile_mk
module tb_mac_tile_mk;
  logic clk = 0, reset_n = 0, mode = 0;
  logic [3:0] in_w = 0, out_e;
  logic [2:0] inst_w = 0, inst_e;
  logic [15:0] in_n = 0, out_s;
  logic mode8 = 0;
  logic [3:0] in_w8 = 0, out_e8;
  logic [2:0] inst_w8 = 0, inst_e8;
  logic [7:0] in_n8 = 0, out_s8;
  int checks = 0, failures = 0;
  int wq[2];
  int nld, rd, acc, ost, ms;
  logic [3:0] me;
  logic [2:0] mie;
  typedef struct {
    logic m;
    logic [2:0] i;
    logic [3:0] a;
    logic [15:0] n;
    logic [15:0] s;
    logic [3:0] e;
    logic [2:0] ie;
  } vec_t;
  vec_t tbl[26];

  mac_tile_mk dut (.clk(clk), .reset_n(reset_n), .mode(mode), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
                   .out_e(out_e), .inst_e(inst_e), .out_s(out_s));
  mac_tile_mk #(.psum_bw(8)) u8 (.clk(clk), .reset_n(reset_n), .mode(mode8), .in_w(in_w8), .inst_w(inst_w8),
                                 .in_n(in_n8), .out_e(out_e8), .inst_e(inst_e8), .out_s(out_s8));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic cyc(input logic m, input logic [2:0] i, input logic [3:0] a, input logic [15:0] n);
    mode = m;
    inst_w = i;
    in_w = a;
    in_n = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    inst_w = 0;
    inst_w8 = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    wq = '{0, 0};
    nld = 0; rd = 0; acc = 0; ost = 0; ms = 0; me = 0; mie = 0;
  endtask

  function automatic int sx4(input logic [3:0] v);
    return int'($signed(v));
  endfunction

  function automatic int fit16(input int x);
`ifdef MAC_TILE_SAT_EN
    return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
`else
    logic [31:0] t;
    t = x;
    return int'($signed(t[15:0]));
`endif
  endfunction

  // behavioural model: a list of loaded weights, a fill count, a read index and an integer accumulator
  task automatic model_step(input logic m, input logic [2:0] i, input logic [3:0] a, input logic [15:0] n);
    int nn;
    nn = int'($signed(n));
    mie = {i[2:1], i[0] & (m | (nld == 2))};
    if (i[0] | i[1]) me = a;
    if (!m) begin
      ms = 0;
      if (i[2]) begin
        nld = 0;
        rd = 0;
      end else begin
        if (i[1]) begin
          ms = fit16(nn + int'(a) * wq[rd]);
          rd = (rd + 1) % 2;
        end
        if (i[0] && nld < 2) begin
          wq[nld] = sx4(a);
          nld++;
        end
      end
      if (ost != 0) begin
        ost = 0;
        acc = 0;
        ms = 0;
      end
    end else if (i[2]) begin
      ms = ost == 2 ? nn : acc;
      acc = 0;
      ost = 2;
    end else if (i[1] && ost != 2) begin
      acc = fit16(acc + int'(a) * sx4(n[3:0]));
      ms = nn;
      ost = 1;
    end else begin
      ms = 0;
      ost = 0;
    end
  endtask

  initial begin
    logic m;
    logic [2:0] ri;
    logic [3:0] ra;
    logic [15:0] rn;
    tbl[0]  = '{1'b0, 3'b001, 4'd3,  16'd0,   16'd0,  4'd3,  3'b000};
    tbl[1]  = '{1'b0, 3'b001, 4'hE,  16'd0,   16'd0,  4'hE,  3'b000};
    tbl[2]  = '{1'b0, 3'b001, 4'd5,  16'd0,   16'd0,  4'd5,  3'b001};
    tbl[3]  = '{1'b0, 3'b010, 4'd2,  16'd10,  16'd16, 4'd2,  3'b010};
    tbl[4]  = '{1'b0, 3'b010, 4'd2,  16'd10,  16'd6,  4'd2,  3'b010};
    tbl[5]  = '{1'b0, 3'b010, 4'd2,  16'd10,  16'd16, 4'd2,  3'b010};
    tbl[6]  = '{1'b0, 3'b100, 4'd9,  16'd10,  16'd0,  4'd2,  3'b100};
    tbl[7]  = '{1'b0, 3'b001, 4'd5,  16'd0,   16'd0,  4'd5,  3'b000};
    tbl[8]  = '{1'b0, 3'b001, 4'd6,  16'd0,   16'd0,  4'd6,  3'b000};
    tbl[9]  = '{1'b0, 3'b010, 4'd1,  16'd0,   16'd5,  4'd1,  3'b010};
    tbl[10] = '{1'b0, 3'b010, 4'd1,  16'd0,   16'd6,  4'd1,  3'b010};
    tbl[11] = '{1'b1, 3'b010, 4'd1,  16'd2,   16'd2,  4'd1,  3'b010};
    tbl[12] = '{1'b1, 3'b010, 4'd2,  16'd2,   16'd2,  4'd2,  3'b010};
    tbl[13] = '{1'b1, 3'b010, 4'd3,  16'd2,   16'd2,  4'd3,  3'b010};
    tbl[14] = '{1'b1, 3'b100, 4'd0,  16'd0,   16'd12, 4'd3,  3'b100};
    tbl[15] = '{1'b1, 3'b100, 4'd0,  16'd7,   16'd7,  4'd3,  3'b100};
    tbl[16] = '{1'b1, 3'b000, 4'd0,  16'd0,   16'd0,  4'd3,  3'b000};
    tbl[17] = '{1'b1, 3'b010, 4'd3,  16'd1,   16'd1,  4'd3,  3'b010};
    tbl[18] = '{1'b1, 3'b110, 4'd5,  16'd1,   16'd3,  4'd5,  3'b110};
    tbl[19] = '{1'b1, 3'b000, 4'd0,  16'd0,   16'd0,  4'd5,  3'b000};
    tbl[20] = '{1'b1, 3'b100, 4'd0,  16'd9,   16'd0,  4'd5,  3'b100};
    tbl[21] = '{1'b1, 3'b000, 4'd0,  16'd0,   16'd0,  4'd5,  3'b000};
    tbl[22] = '{1'b1, 3'b010, 4'd1,  16'd4,   16'd4,  4'd1,  3'b010};
    tbl[23] = '{1'b0, 3'b010, 4'd1,  16'd100, 16'd0,  4'd1,  3'b010};
    tbl[24] = '{1'b1, 3'b100, 4'd0,  16'd0,   16'd0,  4'd1,  3'b100};
    tbl[25] = '{1'b1, 3'b000, 4'd0,  16'd0,   16'd0,  4'd1,  3'b000};

    do_reset();
    chk("rst_out_s", out_s, 0);
    chk("rst_out_e", out_e, 0);
    chk("rst_inst_e", inst_e, 0);

    cyc(1, 3'b010, 4'd3, 16'd3);
    chk("t1_pass_s", out_s, 3);
    #2 reset_n = 0;
    #1;
    chk("t1_async_s", out_s, 0);
    chk("t1_async_e", out_e, 0);
    chk("t1_async_ie", inst_e, 0);
    #2 reset_n = 1;
    cyc(1, 3'b100, 4'd0, 16'd0);
    chk("t1_acc_after_rst", out_s, 0);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      cyc(tbl[i].m, tbl[i].i, tbl[i].a, tbl[i].n);
      chk($sformatf("tbl%0d_s", i), out_s, tbl[i].s);
      chk($sformatf("tbl%0d_e", i), out_e, tbl[i].e);
      chk($sformatf("tbl%0d_ie", i), inst_e, tbl[i].ie);
    end

    do_reset();
    mode8 = 1;
    inst_w8 = 3'b010; in_w8 = 4'd15; in_n8 = 8'd7;
    cyc(0, 3'b000, 4'd0, 16'd0);
    in_n8 = 8'd1;
    cyc(0, 3'b000, 4'd0, 16'd0);
`ifdef MAC_TILE_SAT_EN
    chk("t5_sat_before", u8.sat_seen, 0);
`endif
    in_n8 = 8'd7;
    cyc(0, 3'b000, 4'd0, 16'd0);
    inst_w8 = 3'b100; in_n8 = 8'd0;
    cyc(0, 3'b000, 4'd0, 16'd0);
`ifdef MAC_TILE_SAT_EN
    chk("t5_acc", out_s8, 8'd127);
    chk("t5_sat_seen", u8.sat_seen, 1);
`else
    chk("t5_acc", out_s8, 8'hE1);
`endif
    inst_w8 = 3'b000;

    do_reset();
    m = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) m = ~m;
      ri = 3'($urandom_range(0, 7));
      ra = 4'($urandom);
      rn = 16'($urandom);
      model_step(m, ri, ra, rn);
      cyc(m, ri, ra, rn);
      chk($sformatf("rnd%0d_s", c), out_s, {16'b0, 16'(ms)});
      chk($sformatf("rnd%0d_e", c), out_e, me);
      chk($sformatf("rnd%0d_ie", c), inst_e, mie);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
